// File: rtl/button_debounce_array_if.sv
// Button debouncer bus interface.
//   en         enable for debouncing (master -> slave)
//   noisy_in   raw asynchronous button inputs (master -> slave)
//   level_out  debounced level per channel (slave -> master)
//   pulse_out  one-cycle edge / repeat pulse per channel (slave -> master)
//   any_pulse  OR of pulse_out, registered with it (slave -> master)
interface button_debounce_array_if #(
   parameter int unsigned N_CH = 8
);
   logic            en;
   logic [N_CH-1:0] noisy_in;
   logic [N_CH-1:0] level_out;
   logic [N_CH-1:0] pulse_out;
   logic            any_pulse;

   modport master (
      output en,
      output noisy_in,
      input  level_out,
      input  pulse_out,
      input  any_pulse
   );

   modport slave (
      input  en,
      input  noisy_in,
      output level_out,
      output pulse_out,
      output any_pulse
   );
endinterface

// File: rtl/button_debounce_array.sv
// Multi-channel push-button debouncer.
// Each channel synchronises its raw input, accepts a new level only after STABLE_CYCLES
// consecutive disagreeing samples, and emits a registered one-cycle pulse on accepted edges
// (filtered by EDGE_MODE) plus optional hold-to-repeat pulses.
// Ports:
//   clk     clock
//   rst     asynchronous active-high reset
//   bus_io  slave side of button_debounce_array_if (en, noisy_in in; level_out, pulse_out,
//           any_pulse out)
module button_debounce_array #(
   parameter int unsigned N_CH          = 8,
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned STABLE_CYCLES = 16,
   parameter int unsigned EDGE_MODE     = 0,
   parameter int unsigned REPEAT_EN     = 0,
   parameter int unsigned REPEAT_DELAY  = 1000,
   parameter int unsigned REPEAT_PERIOD = 250
) (
   input  logic                   clk,
   input  logic                   rst,
   button_debounce_array_if.slave bus_io
);

   localparam int unsigned CW     = $clog2(STABLE_CYCLES + 1);
   localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned RW     = $clog2(RepMax + 1);

   localparam logic [CW-1:0] CntLast    = CW'(STABLE_CYCLES - 1);
   localparam logic [RW-1:0] DelayLast  = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] PeriodLast = RW'(REPEAT_PERIOD - 1);

   localparam bit RiseEn = (EDGE_MODE == 0) || (EDGE_MODE == 2);
   localparam bit FallEn = (EDGE_MODE == 1) || (EDGE_MODE == 2);

   logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q, sync_d;
   logic [N_CH-1:0][CW-1:0]          cnt_q, cnt_d;
   logic [N_CH-1:0][RW-1:0]          rep_cnt_q, rep_cnt_d;
   // Set once the first repeat has fired; selects DELAY vs PERIOD as the reload target.
   logic [N_CH-1:0]                  rep_arm_q, rep_arm_d;
   logic [N_CH-1:0]                  level_q, level_d;
   logic [N_CH-1:0]                  pulse_q, pulse_d;
   logic                             any_pulse_q, any_pulse_d;

   logic [N_CH-1:0] sync_s;
   logic            rise, fall, rep_fire;

   assign sync_s = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d    = {sync_q[SYNC_STAGES-2:0], bus_io.noisy_in};
      cnt_d     = cnt_q;
      rep_cnt_d = rep_cnt_q;
      rep_arm_d = rep_arm_q;
      level_d   = level_q;
      pulse_d   = '0;
      rise      = 1'b0;
      fall      = 1'b0;
      rep_fire  = 1'b0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         rise     = 1'b0;
         fall     = 1'b0;
         rep_fire = 1'b0;
         if (!bus_io.en) begin
            // Levels freeze, counters restart from zero when re-enabled.
            cnt_d[i]     = '0;
            rep_cnt_d[i] = '0;
            rep_arm_d[i] = 1'b0;
         end else begin
            if (sync_s[i] == level_q[i]) begin
               cnt_d[i] = '0;
            end else if (cnt_q[i] == CntLast) begin
               level_d[i] = sync_s[i];
               cnt_d[i]   = '0;
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end

            rise = ~level_q[i] & level_d[i];
            fall = level_q[i] & ~level_d[i];

            // Repeat only while the level was high and stays high, so it can never
            // coincide with either edge pulse.
            if ((REPEAT_EN != 0) && level_q[i] && level_d[i]) begin
               if ((!rep_arm_q[i] && (rep_cnt_q[i] == DelayLast)) ||
                   (rep_arm_q[i] && (rep_cnt_q[i] == PeriodLast))) begin
                  rep_fire     = 1'b1;
                  rep_cnt_d[i] = '0;
                  rep_arm_d[i] = 1'b1;
               end else begin
                  rep_cnt_d[i] = rep_cnt_q[i] + 1'b1;
               end
            end else begin
               rep_cnt_d[i] = '0;
               rep_arm_d[i] = 1'b0;
            end

            pulse_d[i] = (RiseEn & rise) | (FallEn & fall) | rep_fire;
         end
      end
      any_pulse_d = |pulse_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q      <= '0;
         cnt_q       <= '0;
         rep_cnt_q   <= '0;
         rep_arm_q   <= '0;
         level_q     <= '0;
         pulse_q     <= '0;
         any_pulse_q <= 1'b0;
      end else begin
         sync_q      <= sync_d;
         cnt_q       <= cnt_d;
         rep_cnt_q   <= rep_cnt_d;
         rep_arm_q   <= rep_arm_d;
         level_q     <= level_d;
         pulse_q     <= pulse_d;
         any_pulse_q <= any_pulse_d;
      end
   end

   assign bus_io.level_out = level_q;
   assign bus_io.pulse_out = pulse_q;
   assign bus_io.any_pulse = any_pulse_q;

endmodule

// File: tb/tb_button_debounce_array.sv
// Directed bench for button_debounce_array: three instances (default rising-edge, both-edge,
// and repeat-enabled) share the same clock, reset, enable and raw inputs.
module tb_button_debounce_array;

   logic       clk;
   logic       rst;
   logic       en;
   logic [7:0] noisy;

   int total = 0;
   int bad   = 0;

   button_debounce_array_if #(.N_CH(8)) if_rise ();
   button_debounce_array_if #(.N_CH(8)) if_both ();
   button_debounce_array_if #(.N_CH(8)) if_rep ();

   assign if_rise.en       = en;
   assign if_rise.noisy_in = noisy;
   assign if_both.en       = en;
   assign if_both.noisy_in = noisy;
   assign if_rep.en        = en;
   assign if_rep.noisy_in  = noisy;

   button_debounce_array #(.N_CH(8)) u_rise (
      .clk    (clk),
      .rst    (rst),
      .bus_io (if_rise)
   );

   button_debounce_array #(.N_CH(8), .EDGE_MODE(2)) u_both (
      .clk    (clk),
      .rst    (rst),
      .bus_io (if_both)
   );

   button_debounce_array #(.N_CH(8), .REPEAT_EN(1), .REPEAT_DELAY(10), .REPEAT_PERIOD(4)) u_rep (
      .clk    (clk),
      .rst    (rst),
      .bus_io (if_rep)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      en    = 1'b1;
      noisy = '0;
      repeat (3) tick();
      total++;
      if (if_rise.level_out !== 8'h00) begin
         bad++;
         $display("FAIL reset_level got=%h exp=00", if_rise.level_out);
      end
      total++;
      if (if_rise.pulse_out !== 8'h00 || if_rise.any_pulse !== 1'b0) begin
         bad++;
         $display("FAIL reset_pulse got=%h/%b exp=00/0", if_rise.pulse_out, if_rise.any_pulse);
      end
      total++;
      if (if_both.level_out !== 8'h00 || if_rep.level_out !== 8'h00) begin
         bad++;
         $display("FAIL reset_level_others got=%h/%h exp=00/00", if_both.level_out,
                  if_rep.level_out);
      end
      rst = 1'b0;
      repeat (5) tick();
      total++;
      if (if_rise.level_out !== 8'h00 || if_rise.pulse_out !== 8'h00) begin
         bad++;
         $display("FAIL idle_after_reset got=%h/%h exp=00/00", if_rise.level_out,
                  if_rise.pulse_out);
      end
   endtask

   task automatic test_clean_rise();
      logic exp_p;
      noisy[0] = 1'b1;
      for (int k = 1; k <= 25; k++) begin
         tick();
         exp_p = (k == 18);
         total++;
         if (if_rise.pulse_out[0] !== exp_p) begin
            bad++;
            $display("FAIL clean_rise_pulse edge=%0d got=%b exp=%b", k, if_rise.pulse_out[0], exp_p);
         end
         if (k == 17 || k == 18) begin
            total++;
            if (if_rise.level_out[0] !== (k == 18)) begin
               bad++;
               $display("FAIL clean_rise_level edge=%0d got=%b exp=%b", k, if_rise.level_out[0],
                        (k == 18));
            end
         end
         if (k == 18) begin
            total++;
            if (if_rise.any_pulse !== 1'b1) begin
               bad++;
               $display("FAIL clean_rise_any got=%b exp=1", if_rise.any_pulse);
            end
         end
      end
      noisy[0] = 1'b0;
      for (int k = 1; k <= 25; k++) begin
         tick();
         total++;
         if (if_rise.pulse_out[0] !== 1'b0) begin
            bad++;
            $display("FAIL rise_mode_no_fall edge=%0d got=%b exp=0", k, if_rise.pulse_out[0]);
         end
      end
      total++;
      if (if_rise.level_out[0] !== 1'b0) begin
         bad++;
         $display("FAIL release_level got=%b exp=0", if_rise.level_out[0]);
      end
   endtask

   task automatic test_bounce();
      int n_pulse = 0;
      noisy[1] = 1'b1;
      for (int k = 1; k <= 50; k++) begin
         tick();
         if (if_rise.pulse_out[1]) n_pulse++;
         total++;
         if (if_rise.pulse_out[1] !== (k == 26)) begin
            bad++;
            $display("FAIL bounce_pulse edge=%0d got=%b exp=%b", k, if_rise.pulse_out[1], (k == 26));
         end
         if (k == 5) noisy[1] = 1'b0;
         if (k == 8) noisy[1] = 1'b1;
      end
      total++;
      if (n_pulse != 1) begin
         bad++;
         $display("FAIL bounce_count got=%0d exp=1", n_pulse);
      end
      noisy[1] = 1'b0;
      repeat (25) tick();
   endtask

   task automatic test_both_edges();
      logic exp_p;
      noisy[2] = 1'b1;
      for (int k = 1; k <= 70; k++) begin
         tick();
         exp_p = (k == 18) || (k == 58);
         total++;
         if (if_both.pulse_out[2] !== exp_p || if_both.any_pulse !== exp_p) begin
            bad++;
            $display("FAIL both_edge edge=%0d got=%b/%b exp=%b", k, if_both.pulse_out[2],
                     if_both.any_pulse, exp_p);
         end
         total++;
         if (if_rise.pulse_out[2] !== (k == 18)) begin
            bad++;
            $display("FAIL rise_only edge=%0d got=%b exp=%b", k, if_rise.pulse_out[2], (k == 18));
         end
         if (k == 40) noisy[2] = 1'b0;
      end
   endtask

   task automatic test_repeat();
      logic exp_p;
      int   n_pulse = 0;
      noisy[3] = 1'b1;
      for (int k = 1; k <= 58; k++) begin
         tick();
         exp_p = (k == 18) || ((k >= 28) && (k <= 56) && (((k - 28) % 4) == 0));
         if (if_rep.pulse_out[3]) n_pulse++;
         total++;
         if (if_rep.pulse_out[3] !== exp_p) begin
            bad++;
            $display("FAIL repeat_pulse edge=%0d got=%b exp=%b", k, if_rep.pulse_out[3], exp_p);
         end
      end
      total++;
      if (n_pulse != 9) begin
         bad++;
         $display("FAIL repeat_count got=%0d exp=9", n_pulse);
      end
      noisy[3] = 1'b0;
      repeat (30) tick();
      total++;
      if (if_rep.level_out[3] !== 1'b0 || if_rise.level_out[3] !== 1'b0) begin
         bad++;
         $display("FAIL repeat_release got=%b/%b exp=0/0", if_rep.level_out[3],
                  if_rise.level_out[3]);
      end
   endtask

   task automatic test_enable();
      en       = 1'b0;
      noisy[5] = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         tick();
         total++;
         if (if_rise.any_pulse !== 1'b0 || if_both.any_pulse !== 1'b0 ||
             if_rep.any_pulse !== 1'b0) begin
            bad++;
            $display("FAIL en0_press_pulse edge=%0d got=%b%b%b exp=000", k, if_rise.any_pulse,
                     if_both.any_pulse, if_rep.any_pulse);
         end
      end
      total++;
      if (if_rise.level_out[5] !== 1'b0) begin
         bad++;
         $display("FAIL en0_level_frozen_low got=%b exp=0", if_rise.level_out[5]);
      end
      en = 1'b1;
      for (int j = 1; j <= 20; j++) begin
         tick();
         total++;
         if (if_rise.pulse_out[5] !== (j == 16) || if_rise.level_out[5] !== (j >= 16)) begin
            bad++;
            $display("FAIL en1_accept edge=%0d got=%b/%b exp=%b/%b", j, if_rise.pulse_out[5],
                     if_rise.level_out[5], (j == 16), (j >= 16));
         end
      end
      en       = 1'b0;
      noisy[5] = 1'b0;
      for (int k = 1; k <= 30; k++) begin
         tick();
         total++;
         if (if_both.any_pulse !== 1'b0 || if_rep.any_pulse !== 1'b0) begin
            bad++;
            $display("FAIL en0_release_pulse edge=%0d got=%b%b exp=00", k, if_both.any_pulse,
                     if_rep.any_pulse);
         end
      end
      total++;
      if (if_rise.level_out[5] !== 1'b1) begin
         bad++;
         $display("FAIL en0_level_frozen_high got=%b exp=1", if_rise.level_out[5]);
      end
      en = 1'b1;
      for (int j = 1; j <= 20; j++) begin
         tick();
         total++;
         if (if_both.pulse_out[5] !== (j == 16) || if_both.level_out[5] !== (j < 16)) begin
            bad++;
            $display("FAIL en1_fall edge=%0d got=%b/%b exp=%b/%b", j, if_both.pulse_out[5],
                     if_both.level_out[5], (j == 16), (j < 16));
         end
         total++;
         if (if_rise.pulse_out[5] !== 1'b0) begin
            bad++;
            $display("FAIL en1_fall_rise_mode edge=%0d got=%b exp=0", j, if_rise.pulse_out[5]);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] exp_p;
      noisy = 8'hFF;
      repeat (25) tick();
      total++;
      if (if_rise.level_out !== 8'hFF) begin
         bad++;
         $display("FAIL all_pressed_level got=%h exp=ff", if_rise.level_out);
      end
      // ch4 held, the rest toggling together; counters are mid-count when reset hits.
      for (int k = 1; k <= 7; k++) begin
         tick();
         noisy = (k % 2 == 1) ? 8'h10 : 8'hFF;
      end
      rst = 1'b1;
      #1;
      total++;
      if (if_rise.level_out !== 8'h00 || if_rise.pulse_out !== 8'h00 ||
          if_rise.any_pulse !== 1'b0) begin
         bad++;
         $display("FAIL async_reset got=%h/%h/%b exp=00/00/0", if_rise.level_out,
                  if_rise.pulse_out, if_rise.any_pulse);
      end
      total++;
      if (if_both.level_out !== 8'h00 || if_rep.level_out !== 8'h00 ||
          if_rep.pulse_out !== 8'h00) begin
         bad++;
         $display("FAIL async_reset_others got=%h/%h/%h exp=00/00/00", if_both.level_out,
                  if_rep.level_out, if_rep.pulse_out);
      end
      for (int k = 1; k <= 3; k++) begin
         tick();
         noisy = (k % 2 == 1) ? 8'h10 : 8'hEF;
      end
      noisy = 8'hFF;
      tick();
      rst = 1'b0;
      for (int k = 1; k <= 25; k++) begin
         tick();
         exp_p = (k == 18) ? 8'hFF : 8'h00;
         total++;
         if (if_rise.pulse_out !== exp_p || if_rise.any_pulse !== (k == 18)) begin
            bad++;
            $display("FAIL post_reset_pulse edge=%0d got=%h/%b exp=%h/%b", k, if_rise.pulse_out,
                     if_rise.any_pulse, exp_p, (k == 18));
         end
         total++;
         if (if_rep.pulse_out !== exp_p) begin
            bad++;
            $display("FAIL post_reset_rep edge=%0d got=%h exp=%h", k, if_rep.pulse_out, exp_p);
         end
         if (k == 17 || k == 18) begin
            total++;
            if (if_rise.level_out !== ((k == 18) ? 8'hFF : 8'h00)) begin
               bad++;
               $display("FAIL post_reset_level edge=%0d got=%h exp=%h", k, if_rise.level_out,
                        ((k == 18) ? 8'hFF : 8'h00));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_clean_rise();
      test_bounce();
      test_both_edges();
      test_repeat();
      test_enable();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
